// File: rtl/frame_sched_pkg.sv
// Shared types and default constants for the camera frame transmit scheduler.
package frame_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    CAPTURE,
    GUARD,
    FETCH,
    SEND,
    GAP,
    NEXT
  } sched_state_t;

  localparam int FRAME_BYTES_DEFAULT     = 6144;
  localparam int CLKS_PER_BIT            = 1085;
  localparam int BYTE_GAP_CYCLES_DEFAULT = 10 * CLKS_PER_BIT;

  // Width for a counter that must hold 0..max_count-1.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// Brings camera VSYNC into the Clk domain and produces one-cycle rise/fall strobes.
module vs_edge_sync
  import frame_sched_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic vs_async,
  output logic vs_rise,
  output logic vs_fall
);

  logic vs_p0, vs_p1, vs_p2;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vs_p0 <= 1'b0;
      vs_p1 <= 1'b0;
      vs_p2 <= 1'b0;
    end else begin
      vs_p0 <= vs_async;
      vs_p1 <= vs_p0;
      vs_p2 <= vs_p1;
    end
  end

  // vs_p0/vs_p1 are the synchronizer pair; vs_p2 is the history flop for edges
  assign vs_rise = vs_p1 & ~vs_p2;
  assign vs_fall = ~vs_p1 & vs_p2;

endmodule

// File: rtl/frame_tx_scheduler.sv
// Arms one-frame capture on request, then streams the frame buffer to the UART
// transmitter byte by byte over a valid/ready handshake.
module frame_tx_scheduler
  import frame_sched_pkg::*;
#(
  parameter int BYTES_PER_FRAME = FRAME_BYTES_DEFAULT,
  parameter int ADDR_W          = 15,
  parameter int PRE_SEND_CYCLES = 62500,
  parameter int BYTE_GAP_CYCLES = BYTE_GAP_CYCLES_DEFAULT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_VS,
  input  logic              i_Start,
  input  logic              i_Continuous,
  input  logic [7:0]        i_Rd_Data,
  input  logic              i_Tx_Ready,
  output logic              o_Capture_En,
  output logic [ADDR_W-1:0] o_Rd_Addr,
  output logic              o_Tx_Valid,
  output logic [7:0]        o_Tx_Data,
  output logic              o_Busy,
  output logic              o_Frame_Done,
  output logic [7:0]        o_Frame_Count
);

  localparam int CNT_MAX = (PRE_SEND_CYCLES > BYTE_GAP_CYCLES) ? PRE_SEND_CYCLES : BYTE_GAP_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_FRAME - 1);
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'((PRE_SEND_CYCLES > 0) ? PRE_SEND_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((BYTE_GAP_CYCLES > 0) ? BYTE_GAP_CYCLES - 1 : 0);

  sched_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             fetch_ph;
  logic             vs_rise, vs_fall;
  logic             more_bytes;

  vs_edge_sync u_vs_sync (
    .Clk      (Clk),
    .Rst      (Rst),
    .vs_async (i_VS),
    .vs_rise  (vs_rise),
    .vs_fall  (vs_fall)
  );

  assign more_bytes = (o_Rd_Addr < LAST_ADDR);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_Start || i_Continuous) state_nxt = ARM;
      ARM:     if (vs_fall) state_nxt = CAPTURE;
      CAPTURE: if (vs_rise) state_nxt = GUARD;
      GUARD:   if (cnt == PRE_LAST) state_nxt = FETCH;
      FETCH:   if (fetch_ph) state_nxt = SEND;
      SEND:    if (i_Tx_Ready) state_nxt = (BYTE_GAP_CYCLES == 0) ? NEXT : GAP;
      GAP:     if (cnt == GAP_LAST) state_nxt = NEXT;
      NEXT: begin
        if (more_bytes)        state_nxt = FETCH;
        else if (i_Continuous) state_nxt = ARM;
        else                   state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // GUARD and GAP share one counter, cleared whenever the state changes
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt           <= '0;
      fetch_ph      <= 1'b0;
      o_Rd_Addr     <= '0;
      o_Tx_Data     <= 8'd0;
      o_Frame_Count <= 8'd0;
    end else begin
      if (state != state_nxt)
        cnt <= '0;
      else if (state == GUARD || state == GAP)
        cnt <= cnt + CNT_W'(1);

      fetch_ph <= (state == FETCH) ? ~fetch_ph : 1'b0;

      if (state == FETCH && fetch_ph)
        o_Tx_Data <= i_Rd_Data;

      if (state == NEXT) begin
        if (more_bytes) begin
          o_Rd_Addr <= o_Rd_Addr + ADDR_W'(1);
        end else begin
          o_Rd_Addr     <= '0;
          o_Frame_Count <= o_Frame_Count + 8'd1;
        end
      end
    end
  end

  assign o_Capture_En = (state == CAPTURE);
  assign o_Tx_Valid   = (state == SEND);
  assign o_Busy       = (state != IDLE);
  assign o_Frame_Done = (state == NEXT) && !more_bytes;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Directed-plus-random bench for frame_tx_scheduler with a transaction-level reference.
module tb_frame_tx_scheduler;

  localparam int BPF  = 4;
  localparam int AW   = 15;
  localparam int PRE  = 8;
  localparam int GAPC = 3;

  logic          Clk;
  logic          Rst;
  logic          i_VS;
  logic          i_Start;
  logic          i_Continuous;
  logic [7:0]    i_Rd_Data;
  logic          i_Tx_Ready;
  logic          o_Capture_En;
  logic [AW-1:0] o_Rd_Addr;
  logic          o_Tx_Valid;
  logic [7:0]    o_Tx_Data;
  logic          o_Busy;
  logic          o_Frame_Done;
  logic [7:0]    o_Frame_Count;

  frame_tx_scheduler #(
    .BYTES_PER_FRAME (BPF),
    .ADDR_W          (AW),
    .PRE_SEND_CYCLES (PRE),
    .BYTE_GAP_CYCLES (GAPC)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .i_VS          (i_VS),
    .i_Start       (i_Start),
    .i_Continuous  (i_Continuous),
    .i_Rd_Data     (i_Rd_Data),
    .i_Tx_Ready    (i_Tx_Ready),
    .o_Capture_En  (o_Capture_En),
    .o_Rd_Addr     (o_Rd_Addr),
    .o_Tx_Valid    (o_Tx_Valid),
    .o_Tx_Data     (o_Tx_Data),
    .o_Busy        (o_Busy),
    .o_Frame_Done  (o_Frame_Done),
    .o_Frame_Count (o_Frame_Count)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] ram [BPF];
  logic [7:0] exp_count = 8'd0;
  bit         rdy_low = 0;
  bit         rdy_rand = 0;

  int         cyc = 0;
  int         done_pulses = 0;
  int         busy_low = 0;
  int         cap_cnt = 0;
  logic [7:0] got_q [$];
  int         hs_cyc [$];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Synchronous RAM: data appears one cycle after the address
  initial begin
    i_Rd_Data = 8'd0;
    forever begin
      @(posedge Clk);
      i_Rd_Data <= (o_Rd_Addr < AW'(BPF)) ? ram[o_Rd_Addr[1:0]] : 8'h00;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: collects accepted bytes and checks handshake stability every cycle
  initial begin : monitor
    logic       prev_v;
    logic       prev_hs;
    logic [7:0] prev_d;
    logic       hs;
    prev_v  = 1'b0;
    prev_hs = 1'b0;
    prev_d  = 8'd0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (Rst) begin
        prev_v = 1'b0;
      end else begin
        if (prev_v && !prev_hs) begin
          chk("valid_held", 32'(o_Tx_Valid), 32'd1);
          chk("data_stable", 32'(o_Tx_Data), 32'(prev_d));
        end
        hs = o_Tx_Valid && i_Tx_Ready;
        if (hs) begin
          got_q.push_back(o_Tx_Data);
          hs_cyc.push_back(cyc);
        end
        if (o_Frame_Done) done_pulses++;
        if (!o_Busy) busy_low++;
        if (o_Capture_En) cap_cnt++;
        prev_v  = o_Tx_Valid;
        prev_hs = hs;
        prev_d  = o_Tx_Data;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #2;
    if (rdy_low)       i_Tx_Ready = 1'b0;
    else if (rdy_rand) i_Tx_Ready = 1'($urandom_range(0, 1));
    else               i_Tx_Ready = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit seen;
    d0   = done_pulses;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_pulses != d0) begin
        seen = 1;
        break;
      end
    end
    chk("frame_done_seen", 32'(seen), 32'd1);
    if (seen) begin
      exp_count = exp_count + 8'd1;
      chk("frame_count", 32'(o_Frame_Count), 32'(exp_count));
      chk("done_single_pulse", 32'(done_pulses - d0), 32'd1);
    end
  endtask

  // Reference: a completed frame is exactly the RAM contents in address order
  task automatic check_frame(input string tag);
    chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(BPF));
    for (int i = 0; i < BPF; i++)
      if (i < got_q.size()) chk({tag, "_byte"}, 32'(got_q[i]), 32'(ram[i]));
    got_q.delete();
    hs_cyc.delete();
  endtask

  task automatic wait_send_addr(input int addr, input int budget, output bit found);
    found = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_Tx_Valid && (int'(o_Rd_Addr) == addr)) begin
        found = 1;
        break;
      end
    end
    chk("send_reached", 32'(found), 32'd1);
  endtask

  initial begin : stimulus
    int  n;
    int  c0;
    int  b0;
    bit  found;
    bit  seen;

    ram[0] = 8'hA1; ram[1] = 8'hB2; ram[2] = 8'hC3; ram[3] = 8'hD4;
    Rst = 1'b1; i_VS = 1'b1; i_Start = 1'b0; i_Continuous = 1'b0; i_Tx_Ready = 1'b1;
    ticks(3);
    chk("rst_capture", 32'(o_Capture_En), 32'd0);
    chk("rst_valid", 32'(o_Tx_Valid), 32'd0);
    chk("rst_addr", 32'(o_Rd_Addr), 32'd0);
    chk("rst_data", 32'(o_Tx_Data), 32'd0);
    chk("rst_busy", 32'(o_Busy), 32'd0);
    chk("rst_done", 32'(o_Frame_Done), 32'd0);
    chk("rst_count", 32'(o_Frame_Count), 32'd0);
    Rst = 1'b0;
    ticks(5);
    chk("idle_after_rst", 32'(o_Busy), 32'd0);

    // Basic frame: capture window, first-byte latency, byte order and spacing
    pulse_start();
    chk("armed", 32'(o_Busy), 32'd1);
    c0 = cap_cnt;
    i_VS = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i == 2) chk("cap_rise_early", 32'(o_Capture_En), 32'd0);
      if (i == 3) chk("cap_rise", 32'(o_Capture_En), 32'd1);
    end
    i_VS = 1'b1;
    n = 0;
    seen = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == 2) chk("cap_fall_early", 32'(o_Capture_En), 32'd1);
      if (i == 3) chk("cap_fall", 32'(o_Capture_En), 32'd0);
      if (o_Tx_Valid) begin
        n = i;
        seen = 1;
        break;
      end
    end
    chk("first_valid_latency", 32'(n), 32'(PRE + 5));
    wait_done(200);
    chk("cap_cycles", 32'(cap_cnt - c0), 32'd50);
    chk("byte_spacing_n", 32'(hs_cyc.size()), 32'(BPF));
    for (int i = 1; i < BPF; i++)
      if (i < hs_cyc.size()) chk("byte_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(2 + 1 + GAPC + 1));
    check_frame("frame1");
    tick();
    chk("idle_after_frame", 32'(o_Busy), 32'd0);

    // Back-pressure on byte 1
    pulse_start();
    i_VS = 1'b0; ticks(12);
    i_VS = 1'b1;
    wait_send_addr(1, 100, found);
    if (found) begin
      rdy_low = 1; i_Tx_Ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (i % 5 == 4) begin
          chk("stall_valid", 32'(o_Tx_Valid), 32'd1);
          chk("stall_data", 32'(o_Tx_Data), 32'(ram[1]));
          chk("stall_addr", 32'(o_Rd_Addr), 32'd1);
        end
      end
      rdy_low = 0;
    end
    wait_done(200);
    check_frame("stall");

    // Start while VS already low: partial frame must not be captured
    i_VS = 1'b0; ticks(8);
    chk("vs_fall_idle_ignored", 32'(o_Busy), 32'd0);
    pulse_start();
    c0 = cap_cnt;
    ticks(20);
    i_VS = 1'b1; ticks(10);
    chk("no_partial_capture", 32'(cap_cnt - c0), 32'd0);
    chk("still_armed", 32'(o_Busy), 32'd1);
    i_VS = 1'b0; ticks(2);
    chk("full_cap_early", 32'(o_Capture_En), 32'd0);
    tick();
    chk("full_cap", 32'(o_Capture_En), 32'd1);
    ticks(20);
    i_VS = 1'b1;
    wait_done(200);
    check_frame("late_start");

    // Continuous mode with random ready, random frame lengths and RAM contents
    rdy_rand = 1;
    i_Continuous = 1'b1;
    tick();
    b0 = busy_low;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < BPF; i++) ram[i] = 8'($urandom_range(0, 255));
      i_VS = 1'b0;
      ticks(int'($urandom_range(5, 40)));
      i_VS = 1'b1;
      if (f == 2) i_Continuous = 1'b0;
      wait_done(600);
      check_frame("cont");
    end
    chk("cont_never_idle", 32'(busy_low - b0), 32'd0);
    tick();
    chk("cont_end_idle", 32'(o_Busy), 32'd0);
    rdy_rand = 0;

    // Reset in the middle of sending byte 2
    ram[0] = 8'hA1; ram[1] = 8'hB2; ram[2] = 8'hC3; ram[3] = 8'hD4;
    pulse_start();
    i_VS = 1'b0; ticks(10);
    i_VS = 1'b1;
    wait_send_addr(2, 200, found);
    chk("pre_rst_data", 32'(o_Tx_Data), 32'hC3);
    Rst = 1'b1;
    #1;
    chk("midrst_capture", 32'(o_Capture_En), 32'd0);
    chk("midrst_valid", 32'(o_Tx_Valid), 32'd0);
    chk("midrst_addr", 32'(o_Rd_Addr), 32'd0);
    chk("midrst_data", 32'(o_Tx_Data), 32'd0);
    chk("midrst_busy", 32'(o_Busy), 32'd0);
    chk("midrst_done", 32'(o_Frame_Done), 32'd0);
    chk("midrst_count", 32'(o_Frame_Count), 32'd0);
    ticks(2);
    Rst = 1'b0;
    exp_count = 8'd0;
    got_q.delete();
    hs_cyc.delete();
    i_VS = 1'b0; ticks(10);
    i_VS = 1'b1; ticks(30);
    chk("post_rst_idle", 32'(o_Busy), 32'd0);
    chk("post_rst_nobytes", 32'(got_q.size()), 32'd0);

    // Start during GUARD is ignored; exactly one frame goes out
    pulse_start();
    i_VS = 1'b0; ticks(10);
    i_VS = 1'b1; ticks(6);
    pulse_start();
    wait_done(200);
    check_frame("guard_start");
    c0 = done_pulses;
    ticks(40);
    chk("guard_start_idle", 32'(o_Busy), 32'd0);
    chk("guard_start_nomore", 32'(got_q.size()), 32'd0);
    chk("guard_start_nodone", 32'(done_pulses - c0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
